vga_fb_arbiter: RTL
===================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_WIDTH, 10, h_count width.
- V_WIDTH, 10, v_count width.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- LEFT_BORDER, 47, h_count offset before active video.
- TOP_BORDER, 32, v_count offset before active video.
- ADDR_WIDTH, 19, frame buffer address width.
- DATA_WIDTH, 8, pixel width.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- h_count, in, H_WIDTH, horizontal counter.
- v_count, in, V_WIDTH, vertical counter.
- host_req, in, 1, host access request, level.
- host_we, in, 1, 1 = write, 0 = read.
- host_addr, in, ADDR_WIDTH, host address.
- host_wdata, in, DATA_WIDTH, host write data.
- host_ack, out, 1, one-cycle completion pulse.
- host_rdata, out, DATA_WIDTH, host read data, held until next read ack.
- mem_addr, out, ADDR_WIDTH, single-port RAM address.
- mem_we, out, 1, RAM write enable.
- mem_wdata, out, DATA_WIDTH, RAM write data.
- mem_rdata, in, DATA_WIDTH, RAM read data, 1-cycle latency.
- pixel_data, out, DATA_WIDTH, display pixel.
- host_stall_cnt, out, 16, saturating count of host wait cycles.

Function
REQ-003 fetch SHALL be asserted when all of the following hold:
- LEFT_BORDER < h_count <= LEFT_BORDER+H_ACTIVE;
- TOP_BORDER < v_count <= TOP_BORDER+V_ACTIVE.
REQ-004 The display SHALL own the RAM on every fetch cycle:
- mem_addr = disp_addr, mem_we = 0.
REQ-005 disp_addr SHALL behave as follows:
- clears to 0 on any cycle with v_count == 0;
- otherwise increments by 1 after each fetch cycle;
- never wraps within a frame (max H_ACTIVE*V_ACTIVE-1).
REQ-006 disp_q SHALL be a register equal to the previous cycle's fetch; pixel_data SHALL be mem_rdata when disp_q = 1, else 0. The result is that the pixel for count cycle N appears in cycle N+1, aligned with a registered video_on.
REQ-007 The FSM SHALL have two states, IDLE and HOST_RSP.
REQ-008 In IDLE with host_req = 1 and fetch = 0, the block SHALL grant the host:
- mem_addr = host_addr, mem_we = host_we, mem_wdata = host_wdata;
- latch host_we into we_q;
- go to HOST_RSP.
REQ-009 In IDLE with host_req = 1 and fetch = 1, the host SHALL wait:
- the FSM stays in IDLE and the display access proceeds unaffected.
REQ-010 In HOST_RSP the block SHALL:
- pulse host_ack for exactly one cycle;
- if we_q = 0, register mem_rdata into host_rdata;
- return to IDLE unconditionally, ignoring host_req this cycle.
REQ-011 Outside HOST_RSP, host_ack SHALL be 0.
REQ-012 In HOST_RSP, a fetch on the same cycle SHALL still drive the RAM per REQ-004. The host's read data is already on mem_rdata from the previous cycle's issue, so no conflict exists.
REQ-013 When no owner drives the RAM, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their previous values.
REQ-014 Host throughput SHALL be at most one access per 2 cycles. The host keeps host_req and its fields stable until host_ack; deasserting early aborts the pending request with no RAM access.
REQ-015 host_stall_cnt SHALL behave as follows:
- increments each cycle the FSM is in IDLE with host_req = 1 and fetch = 1;
- saturates at 16'hFFFF;
- clears to 0 on host_ack.
REQ-016 A write SHALL never be issued on a fetch cycle, and mem_we SHALL never be 1 while disp_q-sourced data is expected.

Reset
REQ-017 On rst_n = 0, asynchronously, the block SHALL reset as follows:
- FSM to IDLE;
- disp_addr, disp_q, we_q to 0;
- host_ack, mem_we to 0;
- host_rdata, mem_addr, mem_wdata to 0;
- host_stall_cnt to 0;
- pixel_data to 0.
REQ-018 Reset asserted while in HOST_RSP SHALL drop the pending ack; no ack is issued after release.
REQ-019 After reset release, the block SHALL act on the first rising clk edge with no warm-up cycles.

Verification
REQ-020 Host write during blanking: h_count=10, v_count=5, host_req=1, host_we=1, addr=100, wdata=8'hA5. Required: mem_we=1 and mem_addr=100 that cycle, host_ack=1 the next cycle, mem_we=0 after.
REQ-021 Host read: after REQ-020, read addr=100 during blanking with RAM model returning A5. Required: host_ack on the 2nd cycle and host_rdata=8'hA5 held afterwards.
REQ-022 Display priority: host_req=1 asserted at h_count=48, v_count=33. Required:
- no grant for 640 cycles;
- mem_addr steps 0..639;
- host_stall_cnt=640 at h_count=688;
- grant at h_count=688; ack next cycle; host_stall_cnt then 0.
REQ-023 Frame addressing: run one full frame (800x525 counts). Required:
- pixel_data nonzero only in the cycle after a fetch;
- last fetch uses disp_addr=307199;
- disp_addr=0 at v_count=0.
REQ-024 Reset mid-access: assert rst_n=0 in HOST_RSP. Required:
- host_ack=0 immediately and all outputs at reset values;
- after release with host_req=1 in blanking, a fresh grant occurs and ack follows 1 cycle later.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port frame buffer arbiter: the raster fetch owns the RAM during active video,
// the host gets the RAM in blanking with a two-cycle request/ack transaction.
module vga_fb_arbiter #(
   parameter int H_WIDTH     = 10,
   parameter int V_WIDTH     = 10,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int LEFT_BORDER = 47,
   parameter int TOP_BORDER  = 32,
   parameter int ADDR_WIDTH  = 19,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [H_WIDTH-1:0]    h_count,
   input  logic [V_WIDTH-1:0]    v_count,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] pixel_data,
   output logic [15:0]           host_stall_cnt
);

   localparam logic [H_WIDTH-1:0]    H_LO      = H_WIDTH'(LEFT_BORDER);
   localparam logic [H_WIDTH-1:0]    H_HI      = H_WIDTH'(LEFT_BORDER + H_ACTIVE);
   localparam logic [V_WIDTH-1:0]    V_LO      = V_WIDTH'(TOP_BORDER);
   localparam logic [V_WIDTH-1:0]    V_HI      = V_WIDTH'(TOP_BORDER + V_ACTIVE);
   localparam logic [ADDR_WIDTH-1:0] DISP_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic {
      IDLE     = 1'b0,
      HOST_RSP = 1'b1
   } state_t;

   state_t                state;
   logic                  fetch;
   logic                  disp_own;
   logic                  host_grant;
   logic                  disp_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] disp_addr;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;

   assign fetch = (h_count > H_LO) && (h_count <= H_HI) &&
                  (v_count > V_LO) && (v_count <= V_HI);

   // Host handshake: host_req is a level held with its fields until host_ack. A grant
   // happens in the same cycle the RAM is free (IDLE, no fetch); host_ack pulses in the
   // following cycle, and read data is registered into host_rdata at the end of that cycle.
   // Ownership is gated by rst_n so the combinational RAM port stays quiet during reset.
   assign disp_own   = rst_n & fetch;
   assign host_grant = rst_n & (state == IDLE) & host_req & ~fetch;

   assign mem_addr   = disp_own   ? disp_addr  :
                       host_grant ? host_addr  : mem_addr_q;
   assign mem_we     = host_grant & host_we;
   assign mem_wdata  = host_grant ? host_wdata : mem_wdata_q;
   assign pixel_data = disp_q ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_addr_q  <= mem_addr;
         mem_wdata_q <= mem_wdata;
      end
   end

   // Display address saturates at the last pixel so a long vertical blank never wraps it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_addr <= '0;
         disp_q    <= 1'b0;
      end else begin
         disp_q <= fetch;
         if (v_count == '0)
            disp_addr <= '0;
         else if (fetch && (disp_addr != DISP_LAST))
            disp_addr <= disp_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         we_q           <= 1'b0;
         host_ack       <= 1'b0;
         host_rdata     <= '0;
         host_stall_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               host_ack <= 1'b0;
               if (host_grant) begin
                  we_q     <= host_we;
                  host_ack <= 1'b1;
                  state    <= HOST_RSP;
               end
            end
            HOST_RSP: begin
               host_ack <= 1'b0;
               if (!we_q)
                  host_rdata <= mem_rdata;
               state <= IDLE;
            end
            default: begin
               host_ack <= 1'b0;
               state    <= IDLE;
            end
         endcase

         if (host_ack)
            host_stall_cnt <= '0;
         else if ((state == IDLE) && host_req && fetch && (host_stall_cnt != 16'hFFFF))
            host_stall_cnt <= host_stall_cnt + 16'd1;
      end
   end

endmodule
